// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  // Byte-offset field width: word select plus the two byte bits.
  function automatic int calc_off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int sets, input int line_words);
    return 32 - $clog2(sets) - $clog2(line_words) - 2;
  endfunction

  // Replace the bytes of word selected by be with the matching bytes of wdata.
  function automatic logic [31:0] merge_bytes(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = word;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? wdata[8*b +: 8] : word[8*b +: 8];
    end
    return res;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/plru_ctl.sv
// Per-set pseudo-LRU state: updated on every access, yields the victim way.
module plru_ctl #(
  parameter int WAYS  = 2,
  parameter int SETS  = 256,
  parameter int IDX_W = 8,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way,
  input  logic [IDX_W-1:0] rd_set,
  output logic [WAY_W-1:0] victim_way
);

  localparam int PW = (WAYS == 4) ? 3 : 1;

  logic [PW-1:0]    plru_r [SETS];
  logic [PW-1:0]    cur_upd_s;
  logic [PW-1:0]    cur_rd_s;
  logic [PW-1:0]    nxt_s;
  logic [WAY_W-1:0] victim_s;

  assign cur_upd_s  = plru_r[upd_set];
  assign cur_rd_s   = plru_r[rd_set];
  assign victim_way = victim_s;

  generate
    if (WAYS == 4) begin : g_tree
      // Tree: bit0 picks the pair, bit1/bit2 pick within the left/right pair.
      always_comb begin
        nxt_s    = cur_upd_s;
        nxt_s[0] = ~upd_way[1];
        if (upd_way[1] == 1'b0) begin
          nxt_s[1] = ~upd_way[0];
        end else begin
          nxt_s[2] = ~upd_way[0];
        end
        if (cur_rd_s[0] == 1'b0) begin
          victim_s = {1'b0, cur_rd_s[1]};
        end else begin
          victim_s = {1'b1, cur_rd_s[2]};
        end
      end
    end else if (WAYS == 2) begin : g_bit
      // Single bit pointing away from the most recently used way.
      always_comb begin
        nxt_s    = ~upd_way;
        victim_s = cur_rd_s;
      end
    end else begin : g_none
      logic unused_way_s;
      assign unused_way_s = ^{upd_way, cur_rd_s};
      // Direct-mapped: the only way is always the victim.
      always_comb begin
        nxt_s    = cur_upd_s;
        victim_s = '0;
      end
    end
  endgenerate

  // Replacement state storage; cleared in a single reset cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        plru_r[s] <= '0;
      end
    end else if (upd_en) begin
      plru_r[upd_set] <= nxt_s;
    end
  end

endmodule

// File: rtl/sa_dcache_wb.sv
// N-way set-associative write-back, write-allocate data cache with miss FSM.
module sa_dcache_wb
  import dcache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  input  logic                    i_we,
  input  logic [31:0]             i_addr,
  input  logic [31:0]             i_wdata,
  input  logic [3:0]              i_be,
  output logic                    o_stall,
  output logic                    o_rvalid,
  output logic [31:0]             o_rdata,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [31:0]             o_mem_addr,
  output logic [32*LINE_WORDS-1:0] o_mem_wline,
  input  logic                    i_mem_ack,
  input  logic [32*LINE_WORDS-1:0] i_mem_rline,
  output logic [31:0]             o_hit_cnt,
  output logic [31:0]             o_miss_cnt
);

  localparam int OFF_W  = calc_off_w(LINE_WORDS);
  localparam int IDX_W  = calc_idx_w(SETS);
  localparam int TAG_W  = calc_tag_w(SETS, LINE_WORDS);
  localparam int WOFF_W = OFF_W - 2;
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_W-1:0]  tag_r   [WAYS][SETS];
  logic [LINE_W-1:0] data_r  [WAYS][SETS];
  logic [SETS-1:0]   valid_r [WAYS];
  logic [SETS-1:0]   dirty_r [WAYS];
  state_t            state_r;
  logic [WAY_W-1:0]  victim_r;

  logic [TAG_W-1:0]  tag_s;
  logic [IDX_W-1:0]  idx_s;
  logic [WOFF_W-1:0] word_s;
  logic              hit_s, inv_s;
  logic [WAY_W-1:0]  hit_way_s, inv_way_s, plru_way_s, victim_s, base_way_s;
  logic [LINE_W-1:0] base_line_s, merged_line_s, wr_line_s;
  logic [31:0]       base_word_s;
  logic              req_hit_s, req_miss_s, ack_s, store_s, fill_s;
  logic              unused_addr_s;

  assign tag_s         = i_addr[31 -: TAG_W];
  assign idx_s         = i_addr[OFF_W +: IDX_W];
  assign word_s        = i_addr[2 +: WOFF_W];
  assign unused_addr_s = ^i_addr[1:0];

  // Tag compare across ways and lowest-index invalid way search.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    inv_s     = 1'b0;
    inv_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_s     = hit_s | (valid_r[w][idx_s] && (tag_r[w][idx_s] == tag_s));
      hit_way_s = (valid_r[w][idx_s] && (tag_r[w][idx_s] == tag_s)) ? WAY_W'(w) : hit_way_s;
      inv_s     = inv_s | ~valid_r[w][idx_s];
      inv_way_s = (~valid_r[w][idx_s]) ? WAY_W'(w) : inv_way_s;
    end
  end

  assign victim_s   = inv_s ? inv_way_s : plru_way_s;
  assign req_hit_s  = (state_r == IDLE) && i_req_valid && hit_s;
  assign req_miss_s = (state_r == IDLE) && i_req_valid && !hit_s;
  assign ack_s      = o_mem_req && i_mem_ack;
  assign fill_s     = (state_r == REFILL) && ack_s;
  assign store_s    = i_we && (|i_be) && (req_hit_s || (state_r == RESPOND));

  // In IDLE the access targets the hit way; after a miss it targets the victim.
  assign base_way_s  = (state_r == IDLE) ? hit_way_s : victim_r;
  assign base_line_s = data_r[base_way_s][idx_s];
  assign base_word_s = base_line_s[{word_s, 5'd0} +: 32];

  // Build the line image for a store: one word byte-merged into the line.
  always_comb begin
    merged_line_s = base_line_s;
    merged_line_s[{word_s, 5'd0} +: 32] = merge_bytes(base_word_s, i_wdata, i_be);
  end

  assign wr_line_s = fill_s ? i_mem_rline : merged_line_s;
  assign o_stall   = rst && (req_miss_s || (state_r == WRITEBACK) || (state_r == REFILL));

  plru_ctl #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .IDX_W (IDX_W)
  ) u_plru (
    .clk        (clk),
    .rst        (rst),
    .upd_en     (req_hit_s || fill_s),
    .upd_set    (idx_s),
    .upd_way    (req_hit_s ? hit_way_s : victim_r),
    .rd_set     (idx_s),
    .victim_way (plru_way_s)
  );

  // Tag and line storage; contents are don't-care until valid is set.
  always_ff @(posedge clk) begin
    if (rst && (store_s || fill_s)) begin
      data_r[base_way_s][idx_s] <= wr_line_s;
    end
    if (rst && fill_s) begin
      tag_r[victim_r][idx_s] <= tag_s;
    end
  end

  // Miss FSM, valid/dirty bookkeeping, registered outputs and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      victim_r    <= '0;
      o_rvalid    <= 1'b0;
      o_rdata     <= 32'd0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_wline <= '0;
      o_hit_cnt   <= 32'd0;
      o_miss_cnt  <= 32'd0;
      for (int w = 0; w < WAYS; w++) begin
        valid_r[w] <= '0;
        dirty_r[w] <= '0;
      end
    end else begin
      o_rvalid <= 1'b0;
      if (store_s) begin
        dirty_r[base_way_s][idx_s] <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (req_hit_s) begin
            o_rvalid  <= 1'b1;
            o_rdata   <= base_word_s;
            o_hit_cnt <= sat_inc(o_hit_cnt);
          end else if (req_miss_s) begin
            o_miss_cnt <= sat_inc(o_miss_cnt);
            victim_r   <= victim_s;
            o_mem_req  <= 1'b1;
            if (valid_r[victim_s][idx_s] && dirty_r[victim_s][idx_s]) begin
              state_r     <= WRITEBACK;
              o_mem_we    <= 1'b1;
              o_mem_addr  <= {tag_r[victim_s][idx_s], idx_s, {OFF_W{1'b0}}};
              o_mem_wline <= data_r[victim_s][idx_s];
            end else begin
              state_r    <= REFILL;
              o_mem_we   <= 1'b0;
              o_mem_addr <= {i_addr[31:OFF_W], {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (ack_s) begin
            o_mem_req <= 1'b0;
            state_r   <= REFILL;
          end
        end
        REFILL: begin
          if (ack_s) begin
            o_mem_req                <= 1'b0;
            state_r                  <= RESPOND;
            o_rvalid                 <= 1'b1;
            o_rdata                  <= i_mem_rline[{word_s, 5'd0} +: 32];
            valid_r[victim_r][idx_s] <= 1'b1;
            dirty_r[victim_r][idx_s] <= 1'b0;
          end else if (!o_mem_req) begin
            // Re-issue after the one-cycle gap that follows a writeback.
            o_mem_req  <= 1'b1;
            o_mem_we   <= 1'b0;
            o_mem_addr <= {i_addr[31:OFF_W], {OFF_W{1'b0}}};
          end
        end
        RESPOND: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
